// File: rtl/tr_in_pipe_if.sv
// Beat bus between the round datapath, tr_in_pipe and the GF(2^4) inversion core.
// Optional parity signals exist only when TR_IN_PIPE_PARITY_EN is defined.
interface tr_in_pipe_if #(
    parameter int LANES = 4
);
    // Valid/ready: a beat moves across a boundary on a rising clk edge where valid
    // and ready are both 1. Once valid is high, the producer holds the beat unchanged
    // until it is taken. A ready never depends combinationally on the valid it gates.
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_encrypt;
    logic [LANES-1:0]     in_lane_en;
    logic [8*LANES-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_encrypt;
    logic [8*LANES-1:0]   out_data;
    logic                 busy;
`ifdef TR_IN_PIPE_PARITY_EN
    logic [LANES-1:0]     in_parity;
    logic [LANES-1:0]     out_parity;
    logic                 par_err;
`endif

    modport slave (
        input  in_valid, in_encrypt, in_lane_en, in_data, out_ready,
`ifdef TR_IN_PIPE_PARITY_EN
        input  in_parity,
        output out_parity, par_err,
`endif
        output in_ready, out_valid, out_encrypt, out_data, busy
    );

    modport master (
        output in_valid, in_encrypt, in_lane_en, in_data, out_ready,
`ifdef TR_IN_PIPE_PARITY_EN
        output in_parity,
        input  out_parity, par_err,
`endif
        input  in_ready, out_valid, out_encrypt, out_data, busy
    );
endinterface

// File: rtl/tr_in_pipe.sv
// Elastic multi-lane S-box input transform: byte G -> tower-field nibbles {A,B}, DEPTH stages.
// Define TR_IN_PIPE_PARITY_EN to add per-lane parity in/out and a sticky parity error flag.
module tr_in_pipe #(
    parameter int LANES = 4,
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    tr_in_pipe_if.slave bus
);
    localparam int W = 8 * LANES;

    if (!(DEPTH == 1 || DEPTH == 2)) begin : g_depth_check
        $error("tr_in_pipe: DEPTH must be 1 or 2");
    end

    // Encrypt: forward basis change. Decrypt: inverse affine folded into the basis change.
    function automatic logic [7:0] f_transform(input logic [7:0] g, input logic enc);
        logic       t0, t1, t2;
        logic [3:0] ia, ib, ka, kb;
        t0    = g[7] ^ g[2];
        t1    = g[6] ^ g[0];
        t2    = t1 ^ g[3];
        ib[3] = ~(t1 ^ g[5]);
        ia[0] = ib[3] ^ g[4];
        ia[2] = ib[3] ^ g[7];
        ia[3] = ib[3] ^ g[1];
        ia[1] = t0 ^ ia[3];
        ka[1] = ~(g[7] ^ g[4]);
        ka[2] = t2 ^ g[1];
        ka[3] = g[6] ^ g[4];
        kb[2] = ia[0] ^ g[1];
        ka[0] = ~(kb[2] ^ g[5]);
        kb[0] = t0 ^ g[5];
        kb[1] = ~(ka[1] ^ g[6]);
        kb[3] = ka[3] ^ t2;
        ib[0] = ~g[0];
        ib[1] = ~(kb[1] ^ ka[2]);
        ib[2] = ~(ka[2] ^ g[2]);
        return enc ? ~{ia, ib} : ~{ka, kb};
    endfunction

    logic [DEPTH-1:0]         r_v;
    logic [DEPTH-1:0]         r_enc;
    logic [DEPTH-1:0][W-1:0]  r_data;
    logic [DEPTH-1:0]         w_ready;
    logic [W-1:0]             w_in_data;
    logic                     w_load;

    // Disabled lanes never see G, so nothing from them reaches stage 1.
    always_comb begin
        w_in_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (bus.in_lane_en[i]) begin
                w_in_data[8*i +: 8] = f_transform(bus.in_data[8*i +: 8], bus.in_encrypt);
            end
        end
    end

    // Stage k can move when any stage from k to the output has a hole, or the sink takes.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_ready[k] = bus.out_ready;
            for (int j = k; j < DEPTH; j++) begin
                if (!r_v[j]) begin
                    w_ready[k] = 1'b1;
                end
            end
        end
    end

    assign w_load = bus.in_valid & w_ready[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_enc  <= '0;
            r_data <= '0;
        end else begin
            if (w_ready[0]) begin
                r_v[0] <= bus.in_valid;
            end
            if (w_load) begin
                r_enc[0]  <= bus.in_encrypt;
                r_data[0] <= w_in_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_ready[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_enc[k]  <= r_enc[k-1];
                        r_data[k] <= r_data[k-1];
                    end
                end
            end
        end
    end

    assign bus.in_ready    = w_ready[0];
    assign bus.out_valid   = r_v[DEPTH-1];
    assign bus.out_encrypt = r_enc[DEPTH-1];
    assign bus.out_data    = r_data[DEPTH-1];
    assign bus.busy        = |r_v;

`ifdef TR_IN_PIPE_PARITY_EN
    logic [DEPTH-1:0][LANES-1:0] r_par;
    logic                        r_par_err;
    logic [LANES-1:0]            w_out_par;
    logic [LANES-1:0]            w_in_bad;

    // Output parity is taken on the transformed byte, so disabled lanes carry 0.
    always_comb begin
        w_out_par = '0;
        w_in_bad  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_out_par[i] = ^w_in_data[8*i +: 8];
            w_in_bad[i]  = bus.in_lane_en[i] & (bus.in_parity[i] ^ (^bus.in_data[8*i +: 8]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par     <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (w_load) begin
                r_par[0] <= w_out_par;
                if (|w_in_bad) begin
                    r_par_err <= 1'b1;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_ready[k] && r_v[k-1]) begin
                    r_par[k] <= r_par[k-1];
                end
            end
        end
    end

    assign bus.out_parity = r_par[DEPTH-1];
    assign bus.par_err    = r_par_err;
`endif
endmodule
